// File: rtl/ysyx22041405_lsu_pkg.sv
// ============================================================================
// ysyx22041405_lsu_pkg : shared constants, state encoding and helpers for the LSU
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package ysyx22041405_lsu_pkg;

  localparam logic [7:0] MASK_BYTE = 8'h01;
  localparam logic [7:0] MASK_HALF = 8'h03;
  localparam logic [7:0] MASK_WORD = 8'h0f;

  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_BUS      = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } lsu_state_e;

  function automatic logic is_misaligned(input logic [7:0] mask, input logic [1:0] off);
    return ((mask == MASK_HALF) && off[0]) || ((mask == MASK_WORD) && (off != 2'b00));
  endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx22041405_lsu_align.sv
// ============================================================================
// ysyx22041405_lsu_align : store data/strobe lane shift and load right-align
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ysyx22041405_lsu_align #(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       st_off_i,
  input  logic [3:0]       st_mask_i,
  input  logic [WIDTH-1:0] st_data_i,
  input  logic [1:0]       ld_off_i,
  input  logic [WIDTH-1:0] ld_data_i,
  output logic [WIDTH-1:0] st_data_o,
  output logic [3:0]       st_strb_o,
  output logic [WIDTH-1:0] ld_data_o
);

  always_comb begin
    st_data_o = st_data_i << {st_off_i, 3'b000};
    st_strb_o = st_mask_i << st_off_i;
    ld_data_o = ld_data_i >> {ld_off_i, 3'b000};
  end

endmodule

`default_nettype wire

// File: rtl/ysyx22041405_lsu.sv
// ============================================================================
// ysyx22041405_lsu : load/store unit between EXU and WBU, one memory op in flight
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ysyx22041405_lsu
  import ysyx22041405_lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_addr,
  input  logic [WIDTH-1:0] in_wdata,
  input  logic             in_ren,
  input  logic             in_wen,
  input  logic [7:0]       in_mask,
  output logic             mem_req,
  input  logic             mem_gnt,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic             mem_rvalid,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dm_addr,
  output logic [WIDTH-1:0] dm_rdata,
  output logic             wb_sel,
  output logic [7:0]       wb_mask,
  output logic [1:0]       out_exc
);

  lsu_state_e       state_q;
  logic             mem_req_q;
  logic             mem_we_q;
  logic [WIDTH-1:0] mem_addr_q;
  logic [WIDTH-1:0] mem_wdata_q;
  logic [3:0]       mem_wstrb_q;
  logic [WIDTH-1:0] op_addr_q;
  logic [7:0]       op_mask_q;
  logic             op_load_q;
  logic             out_valid_q;
  logic             wb_sel_q;
  logic [WIDTH-1:0] dm_addr_q;
  logic [WIDTH-1:0] dm_rdata_q;
  logic [7:0]       wb_mask_q;
  logic [1:0]       out_exc_q;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_drain;
  logic             w_is_mem;
  logic             w_misaligned;
  logic [WIDTH-1:0] w_st_data;
  logic [3:0]       w_st_strb;
  logic [WIDTH-1:0] w_ld_data;

  // Load shift uses the offset latched at accept; store shift uses the live input.
  ysyx22041405_lsu_align #(
    .WIDTH(WIDTH)
  ) u_align (
    .st_off_i  (in_addr[1:0]),
    .st_mask_i (in_mask[3:0]),
    .st_data_i (in_wdata),
    .ld_off_i  (op_addr_q[1:0]),
    .ld_data_i (mem_rdata),
    .st_data_o (w_st_data),
    .st_strb_o (w_st_strb),
    .ld_data_o (w_ld_data)
  );

  always_comb begin
    w_in_ready   = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    w_accept     = in_valid && w_in_ready;
    w_drain      = out_valid_q && out_ready;
    w_is_mem     = in_ren || in_wen;
    w_misaligned = w_is_mem && is_misaligned(in_mask, in_addr[1:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      op_addr_q   <= '0;
      op_mask_q   <= '0;
      op_load_q   <= 1'b0;
      out_valid_q <= 1'b0;
      wb_sel_q    <= 1'b0;
      dm_addr_q   <= '0;
      dm_rdata_q  <= '0;
      wb_mask_q   <= '0;
      out_exc_q   <= EXC_NONE;
    end else begin
      // A new result written below overrides this clear (accept + drain same cycle).
      if (w_drain) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (w_accept) begin
            if (!w_is_mem || w_misaligned) begin
              out_valid_q <= 1'b1;
              wb_sel_q    <= 1'b0;
              dm_addr_q   <= in_addr;
              dm_rdata_q  <= '0;
              wb_mask_q   <= in_mask;
              out_exc_q   <= w_misaligned ? EXC_MISALIGN : EXC_NONE;
            end else begin
              state_q     <= ST_REQ;
              mem_req_q   <= 1'b1;
              mem_we_q    <= in_wen;
              mem_addr_q  <= {in_addr[WIDTH-1:2], 2'b00};
              mem_wdata_q <= w_st_data;
              mem_wstrb_q <= w_st_strb;
              op_addr_q   <= in_addr;
              op_mask_q   <= in_mask;
              op_load_q   <= in_ren;
            end
          end
        end
        ST_REQ: begin
          if (mem_gnt) begin
            mem_req_q <= 1'b0;
            state_q   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b1;
            wb_sel_q    <= op_load_q;
            dm_addr_q   <= op_addr_q;
            dm_rdata_q  <= op_load_q ? w_ld_data : '0;
            wb_mask_q   <= op_mask_q;
            out_exc_q   <= mem_err ? EXC_BUS : EXC_NONE;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    in_ready  = w_in_ready;
    mem_req   = mem_req_q;
    mem_we    = mem_we_q;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    mem_wstrb = mem_wstrb_q;
    out_valid = out_valid_q;
    dm_addr   = dm_addr_q;
    dm_rdata  = dm_rdata_q;
    wb_sel    = wb_sel_q;
    wb_mask   = wb_mask_q;
    out_exc   = out_exc_q;
  end

endmodule

`default_nettype wire
